// File: rtl/id_ex_reg.sv
// id_ex_reg: decode->execute pipeline register with stall, flush and hold refresh.
// Ports: clk/reset(async, low), EN/FLUSH control, D_* bundle in, W_* writeback, E_* out.
// Optional macro BUBBLE_PC_KEEP_EN: a flush keeps D_PC in E_PC instead of zero.
module id_ex_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EN,
  input  logic              FLUSH,
  input  logic [31:0]       D_PC,
  input  logic [31:0]       D_Instr,
  input  logic [31:0]       D_RD1,
  input  logic [31:0]       D_RD2,
  input  logic [31:0]       D_IMMEXT,
  input  logic [4:0]        D_A3,
  input  logic [TNEW_W-1:0] D_TNEW,
  input  logic              W_WE,
  input  logic [4:0]        W_A3,
  input  logic [31:0]       W_WD,
  output logic [31:0]       E_PC,
  output logic [31:0]       E_Instr,
  output logic [31:0]       E_RD1,
  output logic [31:0]       E_RD2,
  output logic [31:0]       E_IMMEXT,
  output logic [4:0]        E_A3,
  output logic [TNEW_W-1:0] E_TNEW,
  output logic              E_VALID
);

  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_rd1;
  logic [31:0]       r_rd2;
  logic [31:0]       r_imm;
  logic [4:0]        r_a3;
  logic [TNEW_W-1:0] r_tnew;
  logic              r_valid;

  logic [31:0] w_flush_pc;
  logic        w_wb_ok;
  logic        w_hit_rs;
  logic        w_hit_rt;

`ifdef BUBBLE_PC_KEEP_EN
  assign w_flush_pc = D_PC;
`else
  assign w_flush_pc = 32'h0;
`endif

  // A held instruction may still be waiting on a result that retires now.
  assign w_wb_ok  = W_WE && (W_A3 != 5'd0) && r_valid;
  assign w_hit_rs = w_wb_ok && (W_A3 == r_instr[25:21]);
  assign w_hit_rt = w_wb_ok && (W_A3 == r_instr[20:16]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_rd1   <= 32'h0;
      r_rd2   <= 32'h0;
      r_imm   <= 32'h0;
      r_a3    <= 5'd0;
      r_tnew  <= '0;
      r_valid <= 1'b0;
    end else if (FLUSH) begin
      r_pc    <= w_flush_pc;
      r_instr <= 32'h0;
      r_rd1   <= 32'h0;
      r_rd2   <= 32'h0;
      r_imm   <= 32'h0;
      r_a3    <= 5'd0;
      r_tnew  <= '0;
      r_valid <= 1'b0;
    end else if (EN) begin
      r_pc    <= D_PC;
      r_instr <= D_Instr;
      r_rd1   <= D_RD1;
      r_rd2   <= D_RD2;
      r_imm   <= D_IMMEXT;
      r_a3    <= D_A3;
      r_tnew  <= D_TNEW;
      r_valid <= 1'b1;
    end else begin
      if (w_hit_rs) r_rd1 <= W_WD;
      if (w_hit_rt) r_rd2 <= W_WD;
    end
  end

  assign E_PC     = r_pc;
  assign E_Instr  = r_instr;
  assign E_RD1    = r_rd1;
  assign E_RD2    = r_rd2;
  assign E_IMMEXT = r_imm;
  assign E_A3     = r_a3;
  assign E_TNEW   = r_tnew;
  assign E_VALID  = r_valid;

endmodule
